// File: rtl/scan_line_scheduler.sv
// Queues beam endpoints and hands them one at a time to a line updater. Issue-to-issue spacing is at least 4 cycles.
// beam_ready drops only when the FIFO is full and no pop is made that cycle; abort flushes the queue and drains the line in flight.
module scan_line_scheduler #(
  parameter int COORD_W = 8,
  parameter int DEPTH   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               beam_valid,
  output logic               beam_ready,
  input  logic [COORD_W-1:0] beam_x,
  input  logic [COORD_W-1:0] beam_y,
  input  logic               beam_last,
  input  logic               abort,
  output logic               line_start,
  output logic [COORD_W-1:0] line_x,
  output logic [COORD_W-1:0] line_y,
  input  logic               line_busy,
  output logic               scan_done,
  output logic [15:0]        beam_count,
  output logic               busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DRAIN} state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               last;
  } beam_t;

  state_t              state_q;
  beam_t               mem_q [DEPTH];
  beam_t               beam_in;
  beam_t               head;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                fifo_empty, push, pop;
  logic                line_start_q, scan_done_q, last_flag_q, drain_seen_q;
  logic [COORD_W-1:0]  line_x_q, line_y_q;
  logic [15:0]         count_q;

  assign beam_in    = '{x: beam_x, y: beam_y, last: beam_last};
  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (cnt_q == '0);
  assign pop        = (state_q == IDLE) && !fifo_empty && !line_busy && !abort;
  assign beam_ready = (cnt_q != FULL_CNT) || pop;
  // A beam offered alongside abort is dropped, never queued.
  assign push       = beam_valid && beam_ready && !abort;
  assign busy       = !fifo_empty || (state_q != IDLE);

  assign line_start = line_start_q;
  assign scan_done  = scan_done_q;
  assign line_x     = line_x_q;
  assign line_y     = line_y_q;
  assign beam_count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= beam_in;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      line_start_q <= 1'b0;
      scan_done_q  <= 1'b0;
      last_flag_q  <= 1'b0;
      drain_seen_q <= 1'b0;
      line_x_q     <= '0;
      line_y_q     <= '0;
      count_q      <= '0;
    end else begin
      line_start_q <= 1'b0;
      scan_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q      <= ISSUE;
            line_x_q     <= head.x;
            line_y_q     <= head.y;
            last_flag_q  <= head.last;
            line_start_q <= 1'b1;
          end
        end
        ISSUE: begin
          drain_seen_q <= 1'b0;
          state_q      <= abort ? DRAIN : WAIT_ACK;
        end
        WAIT_ACK: begin
          if (abort) begin
            state_q      <= DRAIN;
            drain_seen_q <= line_busy;
          end else if (line_busy) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (abort) begin
            state_q      <= DRAIN;
            drain_seen_q <= 1'b1;
          end else if (!line_busy) begin
            state_q <= IDLE;
            // Completing the last beam closes the scan: the count restarts as scan_done fires.
            if (last_flag_q) begin
              count_q     <= '0;
              scan_done_q <= 1'b1;
            end else if (count_q != 16'hFFFF) begin
              count_q <= count_q + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (!drain_seen_q) drain_seen_q <= line_busy;
          else if (!line_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (abort) count_q <= '0;
    end
  end

endmodule
